// File: rtl/sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sound_sequencer
// Purpose  : Priority-arbitrated multi-note tone sequencer driving a shared
//            sine table and producing a volume-scaled sample stream.
// Revision : 1.0 - initial release
// ============================================================================
module sound_sequencer #(
    parameter int NUM_SOUNDS      = 4,
    parameter int NOTES_PER_SOUND = 4,
    parameter int FRAMES_PER_NOTE = 8,
    parameter int TONE_WIDTH      = 4,
    parameter logic [NUM_SOUNDS*NOTES_PER_SOUND*TONE_WIDTH-1:0] NOTE_TABLE = 64'h0F0F_A864_C0CC_2468,
    parameter int PHASE_WIDTH     = 24,
    parameter int INC_SHIFT       = 16,
    parameter int ADDR_WIDTH      = 8,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int SAMPLE_DIV      = 1024
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic [NUM_SOUNDS-1:0]         sound_requests,
    input  logic                          startOfFrame,
    input  logic [2:0]                    volume,
    input  logic                          mute,
    output logic [ADDR_WIDTH-1:0]         table_addr,
    input  logic [SAMPLE_WIDTH-1:0]       table_data,
    output logic [SAMPLE_WIDTH-1:0]       sample_out,
    output logic                          sample_valid,
    output logic                          busy,
    output logic [$clog2(NUM_SOUNDS)-1:0] active_sound
);

    localparam int c_IDX_W   = $clog2(NUM_SOUNDS);
    localparam int c_NOTE_W  = (NOTES_PER_SOUND > 1) ? $clog2(NOTES_PER_SOUND) : 1;
    localparam int c_FRAME_W = (FRAMES_PER_NOTE > 1) ? $clog2(FRAMES_PER_NOTE) : 1;
    localparam int c_DIV_W   = $clog2(SAMPLE_DIV);

    localparam logic [c_NOTE_W-1:0]  c_LAST_NOTE  = c_NOTE_W'(NOTES_PER_SOUND - 1);
    localparam logic [c_FRAME_W-1:0] c_LAST_FRAME = c_FRAME_W'(FRAMES_PER_NOTE - 1);
    localparam logic [c_DIV_W-1:0]   c_LAST_DIV   = c_DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NUM_SOUNDS-1:0]   r_pending;
    logic [c_IDX_W-1:0]      r_active;
    logic [c_NOTE_W-1:0]     r_note;
    logic [c_FRAME_W-1:0]    r_frame;
    logic [PHASE_WIDTH-1:0]  r_phase;
    logic [c_DIV_W-1:0]      r_presc;
    logic                    r_tick_d1;
    logic                    r_tick_d2;
    logic                    r_sample_valid;
    logic [SAMPLE_WIDTH-1:0] r_sample;

    logic [NUM_SOUNDS-1:0]   w_pend_merged;
    logic [NUM_SOUNDS-1:0]   w_clr_mask;
    logic [c_IDX_W-1:0]      w_sel_pend;
    logic [c_IDX_W-1:0]      w_sel_merged;
    logic [c_IDX_W-1:0]      w_start_idx;
    logic                    w_start;
    logic                    w_stop;
    logic                    w_seq_done;
    logic                    w_tick;
    logic                    w_silent;
    logic [TONE_WIDTH-1:0]   w_tone;
    logic signed [SAMPLE_WIDTH-1:0] w_shifted;

    logic [TONE_WIDTH-1:0]   w_tones [NUM_SOUNDS][NOTES_PER_SOUND];

    for (genvar s = 0; s < NUM_SOUNDS; s++) begin : g_sound
        for (genvar n = 0; n < NOTES_PER_SOUND; n++) begin : g_note
            assign w_tones[s][n] = NOTE_TABLE[(s*NOTES_PER_SOUND+n)*TONE_WIDTH +: TONE_WIDTH];
        end
    end

    function automatic logic [c_IDX_W-1:0] f_lowest(input logic [NUM_SOUNDS-1:0] v);
        f_lowest = '0;
        for (int i = NUM_SOUNDS - 1; i >= 0; i--) begin
            if (v[i]) f_lowest = c_IDX_W'(i);
        end
    endfunction

    assign w_tone        = w_tones[r_active][r_note];
    assign w_pend_merged = r_pending | sound_requests;
    assign w_sel_pend    = f_lowest(r_pending);
    assign w_sel_merged  = f_lowest(w_pend_merged);
    assign w_tick        = (r_presc == c_LAST_DIV);
    assign w_seq_done    = startOfFrame && (r_frame == c_LAST_FRAME) && (r_note == c_LAST_NOTE);
    assign w_clr_mask    = w_start ? (NUM_SOUNDS'(1) << w_start_idx) : '0;

    // Lower-or-equal pending index covers both preemption and retrigger.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_idx = w_sel_pend;
        w_stop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if ((|r_pending) && (w_sel_pend <= r_active)) begin
                    w_start = 1'b1;
                end else if (w_seq_done) begin
                    // Same-cycle requests are merged so a follow-on sound needs no IDLE gap.
                    if (|w_pend_merged) begin
                        w_start     = 1'b1;
                        w_start_idx = w_sel_merged;
                    end else begin
                        w_stop      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pending <= '0;
            r_active  <= '0;
            r_note    <= '0;
            r_frame   <= '0;
            r_phase   <= '0;
        end else begin
            r_pending <= w_pend_merged & ~w_clr_mask;
            if (w_start) begin
                r_active <= w_start_idx;
                r_note   <= '0;
                r_frame  <= '0;
                r_phase  <= '0;
            end else if ((r_state == S_IDLE) || w_stop) begin
                r_note   <= '0;
                r_frame  <= '0;
                r_phase  <= '0;
            end else begin
                if (w_tick) begin
                    r_phase <= r_phase + (PHASE_WIDTH'(w_tone) << INC_SHIFT);
                end
                if (startOfFrame) begin
                    if (r_frame == c_LAST_FRAME) begin
                        r_frame <= '0;
                        r_note  <= r_note + 1'b1;
                    end else begin
                        r_frame <= r_frame + 1'b1;
                    end
                end
            end
        end
    end

    // Table data arrives one clock after the address moves, hence two tick delays.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_presc        <= '0;
            r_tick_d1      <= 1'b0;
            r_tick_d2      <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample       <= '0;
        end else begin
            r_presc        <= w_tick ? '0 : r_presc + 1'b1;
            r_tick_d1      <= w_tick;
            r_tick_d2      <= r_tick_d1;
            r_sample_valid <= r_tick_d2;
            if (w_silent) begin
                r_sample <= '0;
            end else if (r_tick_d2) begin
                r_sample <= w_shifted;
            end
        end
    end

    assign w_silent     = mute || (r_state != S_PLAY) || (w_tone == '0);
    assign w_shifted    = $signed(table_data) >>> (3'd7 - volume);
    assign table_addr   = r_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
    assign sample_out   = r_sample;
    assign sample_valid = r_sample_valid;
    assign busy         = (r_state == S_PLAY);
    assign active_sound = r_active;

endmodule
`default_nettype wire

// File: tb/tb_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_sequencer
// Purpose  : Directed, table-driven self-checking bench for sound_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sound_sequencer;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [3:0]  sound_requests = 4'b0000;
    logic        startOfFrame = 1'b0;
    logic [2:0]  volume = 3'd7;
    logic        mute = 1'b0;
    logic [7:0]  table_addr;
    logic [15:0] table_data = 16'h4000;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic [1:0]  active_sound;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  vol;
        logic        mute;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];
    logic [3:0] m_cnt;
    bit t0, t1, t2, t3, ok;

    sound_sequencer #(.SAMPLE_DIV(16)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .sound_requests (sound_requests),
        .startOfFrame   (startOfFrame),
        .volume         (volume),
        .mute           (mute),
        .table_addr     (table_addr),
        .table_data     (table_data),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .busy           (busy),
        .active_sound   (active_sound)
    );

    always #5 clk = ~clk;

    // Reference sample-tick timer: a tick whenever the count sits at 15.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) m_cnt <= 4'd0;
        else         m_cnt <= (m_cnt == 4'd15) ? 4'd0 : m_cnt + 4'd1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] m);
        sound_requests = m;
        step(1);
        sound_requests = 4'b0000;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step(1);
            startOfFrame = 1'b0;
            step(1);
        end
    endtask

    task automatic addr_step(input string name, input logic [7:0] exp);
        logic [7:0] a0;
        logic [7:0] d;
        a0 = table_addr;
        step(16);
        d = table_addr - a0;
        check(name, 32'(d), 32'(exp));
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (sample_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h8000, 3'd5, 1'b0, 16'hE000};
        vecs[1] = '{16'h8000, 3'd7, 1'b0, 16'h8000};
        vecs[2] = '{16'h8000, 3'd0, 1'b0, 16'hFF00};
        vecs[3] = '{16'h4000, 3'd7, 1'b0, 16'h4000};
        vecs[4] = '{16'h4000, 3'd6, 1'b0, 16'h2000};
        vecs[5] = '{16'h7FFF, 3'd3, 1'b0, 16'h07FF};
        vecs[6] = '{16'h1234, 3'd4, 1'b0, 16'h0246};
        vecs[7] = '{16'h8000, 3'd5, 1'b1, 16'h0000};
        vecs[8] = '{16'hFFFF, 3'd7, 1'b0, 16'hFFFF};
        vecs[9] = '{16'hFFFF, 3'd0, 1'b0, 16'hFFFF};

        // Reset state
        step(3);
        check("rst_busy", busy, 0);
        check("rst_addr", table_addr, 0);
        check("rst_sample", sample_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_active", active_sound, 0);
        resetN = 1'b1;
        step(2);

        // Sound 1: start latency, tone 12 steps, rest note, end after 32 frames
        pulse(4'b0010);
        check("s1_busy_c1", busy, 0);
        step(1);
        check("s1_busy_c2", busy, 1);
        check("s1_active", active_sound, 1);
        addr_step("s1_step_a", 8'h0C);
        addr_step("s1_step_b", 8'h0C);
        step(4);
        check("s1_sample", sample_out, 16'h4000);
        frames(16);
        addr_step("s1_rest_step", 8'h00);
        check("s1_rest_sample", sample_out, 0);
        frames(15);
        check("s1_busy_31", busy, 1);
        frames(1);
        check("s1_busy_end", busy, 0);
        check("s1_sample_end", sample_out, 0);

        // Preemption: sound 1 playing, sound 0 requested
        pulse(4'b0010);
        step(6);
        pulse(4'b0001);
        check("pre_active_c1", active_sound, 1);
        step(1);
        check("pre_active_c2", active_sound, 0);
        check("pre_busy", busy, 1);
        check("pre_addr0", table_addr, 0);
        addr_step("pre_step", 8'h08);

        // Queueing: sound 3 waits behind sound 0, then follows without a gap
        pulse(4'b1000);
        step(1);
        check("q_active", active_sound, 0);
        frames(31);
        check("q_busy_31", busy, 1);
        check("q_active_31", active_sound, 0);
        startOfFrame = 1'b1;
        step(1);
        startOfFrame = 1'b0;
        check("q_busy_hand", busy, 1);
        check("q_active_hand", active_sound, 3);
        check("q_addr0", table_addr, 0);
        addr_step("q_step", 8'h0F);

        // Retrigger of sound 3 restarts the full 32-frame sequence
        frames(10);
        pulse(4'b1000);
        step(1);
        check("rt_addr0", table_addr, 0);
        frames(31);
        check("rt_busy_31", busy, 1);
        frames(1);
        check("rt_busy_end", busy, 0);

        // Sample scaling vectors on sound 2 (tone 4 at note 0)
        pulse(4'b0100);
        step(1);
        check("s2_active", active_sound, 2);
        for (int v = 0; v < 10; v++) begin
            table_data = vecs[v].data;
            volume     = vecs[v].vol;
            mute       = vecs[v].mute;
            wait_valid(ok);
            check($sformatf("vec%0d_valid_seen_a", v), ok, 1);
            wait_valid(ok);
            check($sformatf("vec%0d_valid_seen_b", v), ok, 1);
            check($sformatf("vec%0d_sample", v), sample_out, vecs[v].exp);
        end

        // sample_valid exactly three cycles after each tick
        table_data = 16'h8000;
        volume     = 3'd5;
        mute       = 1'b0;
        step(2);
        t0 = 0; t1 = 0; t2 = 0; t3 = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            t3 = t2; t2 = t1; t1 = t0;
            t0 = (m_cnt == 4'd15);
            if (i >= 3) begin
                check("valid_timing", sample_valid, t3);
                if (t3) check("valid_value", sample_out, 16'hE000);
            end
        end

        // Reset mid-sound with sound 2 pending
        table_data = 16'h4000;
        volume     = 3'd7;
        pulse(4'b0001);
        step(1);
        pulse(4'b0100);
        step(20);
        check("mr_busy_pre", busy, 1);
        check("mr_active_pre", active_sound, 0);
        check("mr_sample_pre", sample_out, 16'h4000);
        resetN = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_active", active_sound, 0);
        check("mr_addr", table_addr, 0);
        check("mr_sample", sample_out, 0);
        check("mr_valid", sample_valid, 0);
        step(3);
        resetN = 1'b1;
        step(40);
        check("mr_idle_busy", busy, 0);
        check("mr_idle_sample", sample_out, 0);

        // All four requests in one cycle play back to back
        pulse(4'b1111);
        step(1);
        check("all_active0", active_sound, 0);
        check("all_busy0", busy, 1);
        for (int s = 0; s < 4; s++) begin
            frames(31);
            check($sformatf("all_s%0d_active_31", s), active_sound, s);
            check($sformatf("all_s%0d_busy_31", s), busy, 1);
            startOfFrame = 1'b1;
            step(1);
            startOfFrame = 1'b0;
            if (s < 3) begin
                check($sformatf("all_s%0d_next", s), active_sound, s + 1);
                check($sformatf("all_s%0d_busy_next", s), busy, 1);
            end else begin
                check("all_done_busy", busy, 0);
            end
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sound_sequencer.md
# sound_sequencer

Parametrised multi-channel sound sequencer that turns game-event pulses into timed multi-note tone sequences. It accepts any number of sound request lines, arbitrates by fixed priority, and steps through per-sound note lists paced by `startOfFrame`. A phase accumulator addresses the shared sine table, and the block produces a volume-scaled sample stream for the audio codec controller. It replaces the fixed single-tone mux/prescaler chain inside the sound unit.

## Interface
- `NUM_SOUNDS`, 4: number of request channels; index 0 has the highest priority.
- `NOTES_PER_SOUND`, 4: notes per sound sequence.
- `FRAMES_PER_NOTE`, 8: `startOfFrame` pulses per note; must be ≥1.
- `TONE_WIDTH`, 4: width of a tone code; tone 0 is a rest.
- `NOTE_TABLE`, 64'h0F0F_A864_C0CC_2468: packed tone codes. Note n of sound s is at bits [(s*NOTES_PER_SOUND+n)*TONE_WIDTH +: TONE_WIDTH].
- `PHASE_WIDTH`, 24: phase accumulator width.
- `INC_SHIFT`, 16: phase increment = tone << INC_SHIFT.
- `ADDR_WIDTH`, 8: sine-table address width.
- `SAMPLE_WIDTH`, 16: signed sample width.
- `SAMPLE_DIV`, 1024: clocks per sample tick; must be ≥4.
- `clk`  in  1  system clock, 50 MHz.
- `resetN`  in  1  asynchronous, active-low reset.
- `sound_requests`  in  NUM_SOUNDS  one-cycle request pulses, one bit per sound.
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `volume`  in  3  output attenuation; 7 is full scale.
- `mute`  in  1  forces the sample output to 0.
- `table_addr`  out  ADDR_WIDTH  sine-table address; equals phase[PHASE_WIDTH-1 -: ADDR_WIDTH].
- `table_data`  in  SAMPLE_WIDTH  signed table output, valid one clock after `table_addr`.
- `sample_out`  out  SAMPLE_WIDTH  signed sample to the codec.
- `sample_valid`  out  1  one-cycle strobe marking a new `sample_out`.
- `busy`  out  1  high while in the PLAY state.
- `active_sound`  out  $clog2(NUM_SOUNDS)  index of the sound currently playing.

## Operation
- `pending` register, NUM_SOUNDS bits:
  - a set bit means a request is waiting;
  - `pending |= sound_requests` every cycle;
  - the selected bit is cleared at the moment its sound starts.
- FSM states: IDLE and PLAY.
  - IDLE → PLAY when `pending` != 0. Select the lowest set index, load note 0, clear the frame counter and the phase.
  - PLAY, preemption: a pending index lower than `active_sound` restarts playback with that sound (note 0, phase 0, frame count 0) on the next cycle.
  - PLAY, retrigger: a new request for `active_sound` restarts that sound at note 0.
  - PLAY, queueing: requests for a higher index stay pending.
  - PLAY, note stepping: each `startOfFrame` increments the frame counter. When it reaches FRAMES_PER_NOTE, it clears and the note index advances.
  - PLAY, end of sequence: after the last note expires, start the lowest pending sound if any; otherwise go to IDLE.
- Sample ticks:
  - The prescaler counts 0..SAMPLE_DIV-1 and free-runs from reset. The tick fires when the count is SAMPLE_DIV-1.
  - On each tick in PLAY, phase += current tone << INC_SHIFT, with modulo 2^PHASE_WIDTH wrap.
  - In IDLE the phase is held at 0.
- Sample value:
  - `sample_out` = `table_data` >>> (7 − `volume`), arithmetic shift with sign preserved.
  - `sample_out` is forced to 0 when `mute`=1, in IDLE, or when the current tone is 0.

## Timing
- Reset values: `table_addr`=0, `sample_out`=0, `sample_valid`=0, `busy`=0, `active_sound`=0. Pending, phase, prescaler, frame and note counters are all 0.
- Reset mid-sound silences the output immediately and discards all pending requests.
- Start latency: a request pulse in cycle C gives `busy`=1 and an updated `active_sound` in cycle C+2 (latch at C+1, FSM load at C+2). Preemption has the same latency.
- Sample pipeline for a tick in cycle T:
  - the phase register updates at T+1, so `table_addr` changes at T+1;
  - `table_data` is sampled at T+2;
  - `sample_out` is registered and `sample_valid`=1 during T+3 only.
- Simultaneous events:
  - A `startOfFrame` in the same cycle a sound (re)starts is not counted.
  - A request arriving in the same cycle the last note expires is served without passing through IDLE if it is the lowest pending index.
  - Multiple request bits in one cycle: the lowest index plays and the others queue.
- A sound lasts exactly NOTES_PER_SOUND × FRAMES_PER_NOTE counted frames.

## Test plan
- Reset, then `sound_requests`=4'b0010 → `busy`=1 and `active_sound`=1 two cycles later. `table_addr` steps by 0x0C per tick (tone 12, inc 0xC0000). After 32 counted `startOfFrame` pulses, `busy`=0 and `sample_out`=0.
- Sound 1 playing, then request sound 0 → restart within 2 cycles; `active_sound`=0; first note tone 8 gives an address step of 0x08 per tick.
- Sound 0 playing, then request sound 3 → sound 3 waits. When sound 0 ends after 32 frames, `active_sound`=3 starts in the same cycle, `busy` stays high, and tone 15 gives a step of 0x0F.
- `table_data` driven to 16'h8000, `volume`=5 → `sample_out`=16'hE000 with `sample_valid` asserted 3 cycles after the tick. With `mute`=1 → 0. During sound 1 note 2 (rest) → 0.
- Assert `resetN`=0 mid-sound with sound 2 pending → all outputs are 0 immediately, and after release the block stays idle with no request.
- `sound_requests`=4'b1111 in one cycle → sounds play in order 0, 1, 2, 3 back to back, 128 frames in total.
